// File: rtl/noun_loader.sv
// Host-side noun image loader: parses a framed, XOR-checksummed byte stream and
// writes the payload words into RAM through the memory_unit command interface.
module noun_loader #(
    parameter int          ADDR_W     = 10,
    parameter int          DATA_W     = 32,
    parameter logic [1:0]  FUNC_WRITE = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              mem_ready,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] start_addr
);
    localparam int BPW = DATA_W / 8;
    localparam int CW  = $clog2(BPW) + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_ISSUE,
        S_WAIT,
        S_CSUM
    } state_t;

    state_t            state, next_state;
    logic [31:0]       hdr;
    logic [15:0]       base, count, idx, idx_next, word_addr;
    logic [CW-1:0]     bcnt;
    logic [DATA_W-1:0] asm_word, asm_next;
    logic [7:0]        csum;
    logic              wait_first;
    logic              xfer, hdr_end, word_end;

    assign base      = hdr[15:0];
    assign count     = hdr[31:16];
    assign idx_next  = idx + 16'd1;
    assign word_addr = base + idx;
    assign xfer      = rx_valid & rx_ready;
    assign hdr_end   = (bcnt == CW'(3));
    assign word_end  = (bcnt == CW'(BPW - 1));

    always_comb begin
        asm_next = asm_word;
        asm_next[{bcnt, 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (xfer) next_state = S_HDR;
            // COUNT's high byte is the one arriving now, so decide on it directly
            S_HDR:   if (xfer && hdr_end)
                         next_state = ({rx_data, hdr[23:16]} == 16'd0) ? S_CSUM : S_DATA;
            S_DATA:  if (xfer && word_end) next_state = S_ISSUE;
            S_ISSUE: if (mem_ready) next_state = S_WAIT;
            S_WAIT:  if (!wait_first && mem_ready)
                         next_state = (idx_next == count) ? S_CSUM : S_DATA;
            S_CSUM:  if (xfer) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_execute = (state == S_ISSUE) && mem_ready && !rst;
        mem_func    = mem_execute ? FUNC_WRITE : 2'b00;
        busy        = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready   <= 1'b0;
            hdr        <= '0;
            idx        <= '0;
            bcnt       <= '0;
            asm_word   <= '0;
            csum       <= '0;
            wait_first <= 1'b0;
            address    <= '0;
            write_data <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            start_addr <= '0;
        end else begin
            // rx_ready follows the state being entered, so it is low for all of ISSUE/WAIT
            rx_ready   <= (next_state inside {S_IDLE, S_HDR, S_DATA, S_CSUM});
            done       <= 1'b0;
            wait_first <= (state == S_ISSUE) && mem_ready;
            if (xfer) csum <= (state == S_IDLE) ? rx_data : (csum ^ rx_data);
            case (state)
                S_IDLE: if (xfer) begin
                    hdr[7:0] <= rx_data;
                    bcnt     <= CW'(1);
                    idx      <= '0;
                    error    <= 1'b0;
                end
                S_HDR: if (xfer) begin
                    hdr[{bcnt[1:0], 3'b000} +: 8] <= rx_data;
                    bcnt <= hdr_end ? '0 : bcnt + CW'(1);
                end
                S_DATA: if (xfer) begin
                    asm_word <= asm_next;
                    if (word_end) begin
                        bcnt       <= '0;
                        write_data <= asm_next;
                        address    <= word_addr[ADDR_W-1:0];
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                S_WAIT: if (!wait_first && mem_ready) idx <= idx_next;
                S_CSUM: if (xfer) begin
                    if ((csum ^ rx_data) == 8'd0) begin
                        done       <= 1'b1;
                        start_addr <= base[ADDR_W-1:0];
                    end else begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_noun_loader.sv
// Self-checking bench for noun_loader: table-driven frames, hand-written stall and
// reset sequences, and random frames checked against a frame-level write model.
module tb_noun_loader;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk, rst;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ready;
    logic          mem_ready, mem_execute;
    logic [1:0]    mem_func;
    logic [AW-1:0] address, start_addr;
    logic [DW-1:0] write_data;
    logic          busy, done, error;

    noun_loader #(.ADDR_W(AW), .DATA_W(DW), .FUNC_WRITE(2'b10)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_ready(mem_ready), .mem_execute(mem_execute), .mem_func(mem_func),
        .address(address), .write_data(write_data), .busy(busy), .done(done),
        .error(error), .start_addr(start_addr)
    );

    typedef struct {
        logic [15:0]       base;
        int                count;
        logic [3:0][15:0]  w;
        logic [7:0]        corrupt;
        logic              exp_done;
        logic              exp_err;
    } vec_t;

    int            tests = 0, fails = 0;
    logic [AW-1:0] got_a[$];
    logic [DW-1:0] got_d[$];
    logic [15:0]   fw[$];
    logic [AW-1:0] model_start;
    logic          rand_ready = 0, ready_force = 1;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        mem_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_execute === 1'b1) begin
                got_a.push_back(address);
                got_d.push_back(write_data);
                chk("mem_func_write", {30'd0, mem_func}, 32'd2);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout: rx_ready stayed %b, required 1", rx_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rx_valid = 0;
    endtask

    // Sends a frame built from fw; stall_word stalls mem_ready around that word's
    // ISSUE, abort_after >= 0 stops after that many data bytes.
    task automatic send_frame(input logic [15:0] base, input int count, input logic [7:0] corrupt,
                              input int stall_word, input int abort_after);
        logic [7:0] b[$];
        logic [7:0] cs;
        logic [15:0] c16;
        int bad;
        c16 = 16'(count);
        b.push_back(base[7:0]); b.push_back(base[15:8]);
        b.push_back(c16[7:0]);  b.push_back(c16[15:8]);
        for (int k = 0; k < count; k++) begin
            b.push_back(fw[k][7:0]);
            b.push_back(fw[k][15:8]);
        end
        cs = 8'h00;
        foreach (b[k]) cs = cs ^ b[k];
        b.push_back(cs ^ corrupt);
        for (int i = 0; i < b.size(); i++) begin
            logic last_of_word;
            int wi;
            if (abort_after >= 0 && i == 4 + abort_after) return;
            last_of_word = (i >= 4) && (i < b.size() - 1) && (((i - 4) % 2) == 1);
            wi = (i - 4) / 2;
            if (last_of_word && wi == stall_word) begin
                ready_force = 0;
                @(negedge clk);
            end
            send_byte(b[i]);
            if (i == 0) begin
                chk("first_byte_clears_error", {31'd0, error}, 32'd0);
                chk("busy_in_frame", {31'd0, busy}, 32'd1);
            end
            if (last_of_word) begin
                if (wi == stall_word) begin
                    rx_data  = b[i+1];
                    rx_valid = 1;
                    bad = 0;
                    repeat (20) begin
                        @(negedge clk);
                        if (rx_ready !== 1'b0 || mem_execute !== 1'b0) bad++;
                    end
                    chk("stall_quiet_cycles", bad, 0);
                    ready_force = 1;
                end else if (!rand_ready) begin
                    chk("issue_latency", {31'd0, mem_execute}, 32'd1);
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] base, input int count,
                               input logic exp_done, input logic exp_err);
        if (exp_done) model_start = base[AW-1:0];
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, "_start_addr"}, {24'd0, start_addr}, {24'd0, model_start});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse_ends"}, {31'd0, done}, 32'd0);
        chk({tag, "_error_sticky"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, "_write_count"}, got_a.size(), count);
        for (int k = 0; k < count && k < got_a.size(); k++) begin
            chk({tag, "_write_addr"}, {24'd0, got_a[k]}, {24'd0, 8'(base[7:0] + k)});
            chk({tag, "_write_data"}, {16'd0, got_d[k]}, {16'd0, fw[k]});
        end
        got_a.delete();
        got_d.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_mem_execute"}, {31'd0, mem_execute}, 32'd0);
        chk({tag, "_mem_func"}, {30'd0, mem_func}, 32'd0);
        chk({tag, "_address"}, {24'd0, address}, 32'd0);
        chk({tag, "_write_data"}, {16'd0, write_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_start_addr"}, {24'd0, start_addr}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{base: 16'h0001, count: 2, w: {16'h0, 16'h0, 16'h2222, 16'h1111}, corrupt: 8'h00, exp_done: 1, exp_err: 0};
        vecs[1] = '{base: 16'h0040, count: 0, w: '0, corrupt: 8'h00, exp_done: 1, exp_err: 0};
        vecs[2] = '{base: 16'h0005, count: 2, w: {16'h0, 16'h0, 16'h5555, 16'hAAAA}, corrupt: 8'h01, exp_done: 0, exp_err: 1};
        vecs[3] = '{base: 16'h0007, count: 1, w: {16'h0, 16'h0, 16'h0, 16'h1234}, corrupt: 8'h00, exp_done: 1, exp_err: 0};
        vecs[4] = '{base: 16'h00FF, count: 2, w: {16'h0, 16'h0, 16'hCAFE, 16'hBEEF}, corrupt: 8'h00, exp_done: 1, exp_err: 0};
        vecs[5] = '{base: 16'h1234, count: 3, w: {16'h0, 16'h0C0D, 16'h0A0B, 16'h0809}, corrupt: 8'h00, exp_done: 1, exp_err: 0};

        rst = 1; rx_valid = 0; rx_data = 8'h00; model_start = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        foreach (vecs[v]) begin
            fw.delete();
            for (int k = 0; k < vecs[v].count; k++) fw.push_back(vecs[v].w[k]);
            send_frame(vecs[v].base, vecs[v].count, vecs[v].corrupt, -1, -1);
            check_frame($sformatf("vec%0d", v), vecs[v].base, vecs[v].count,
                        vecs[v].exp_done, vecs[v].exp_err);
            repeat (2) @(negedge clk);
        end

        // Stall mem_ready for 20 cycles while a byte is held on the stream.
        fw.delete();
        fw.push_back(16'h1357); fw.push_back(16'h2468); fw.push_back(16'h9ABC);
        send_frame(16'h0020, 3, 8'h00, 1, -1);
        check_frame("stall", 16'h0020, 3, 1, 0);

        // Reset after the third data byte, then a clean frame.
        fw.delete();
        fw.push_back(16'h4321); fw.push_back(16'h8765);
        send_frame(16'h0030, 2, 8'h00, -1, 3);
        rst = 1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 0;
        model_start = '0;
        repeat (5) @(negedge clk);
        chk("midreset_write_count", got_a.size(), 1);
        if (got_a.size() > 0) begin
            chk("midreset_write_addr", {24'd0, got_a[0]}, 32'h30);
            chk("midreset_write_data", {16'd0, got_d[0]}, 32'h4321);
        end
        got_a.delete();
        got_d.delete();
        send_frame(16'h0030, 2, 8'h00, -1, -1);
        check_frame("after_reset", 16'h0030, 2, 1, 0);

        rand_ready = 1;
        for (int r = 0; r < 25; r++) begin
            logic [15:0] base;
            logic [7:0]  corrupt;
            int          count;
            base    = 16'($urandom);
            count   = $urandom_range(0, 5);
            corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            fw.delete();
            for (int k = 0; k < count; k++) fw.push_back(16'($urandom));
            send_frame(base, count, corrupt, -1, -1);
            check_frame($sformatf("rand%0d", r), base, count, corrupt == 8'h00, corrupt != 8'h00);
        end
        rand_ready = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
